hazard_detect: RTL and testbench

Producer side of the ID-stage forwarding path. The block keeps its own copy of the destination register and write-back select for the EX and MEM stages. Each cycle it compares the ID-stage source registers against those copies. From the result it drives the seven hazard flags consumed by `forward`, plus the pipeline stall and bubble controls for load-use and other non-forwardable cases.

---
 rtl/hazard_detect_pkg.sv | 18 +
 rtl/hazard_dst_reg.sv | 47 ++++
 rtl/hazard_detect.sv | 100 ++++++++++
 tb/tb_hazard_detect.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/hazard_detect_pkg.sv
// Write-back select codes shared with the forwarding muxes, plus a helper that
// classifies which codes cannot be forwarded out of EX.
package hazard_detect_pkg;

   localparam logic [2:0] WB_ALU = 3'b001;
   localparam logic [2:0] WB_RS  = 3'b010;
   localparam logic [2:0] WB_RAM = 3'b011;
   localparam logic [2:0] WB_HI  = 3'b100;
   localparam logic [2:0] WB_LO  = 3'b101;
   localparam logic [2:0] WB_PC8 = 3'b110;

   // Values produced late in EX (or not at all until MEM) must stall instead of forward.
   function automatic logic is_ex_nonfwd(input logic [2:0] wsel);
      return (wsel == WB_RAM) || (wsel == WB_PC8) || (wsel == WB_HI) ||
             (wsel == WB_LO)  || (wsel == WB_RS);
   endfunction

endpackage

// File: rtl/hazard_dst_reg.sv
// One pipeline tracking entry {wen, wreg, wsel}; loads when enabled, or becomes a
// bubble (all fields zero) when clear is also asserted.
module hazard_dst_reg
   import hazard_detect_pkg::*;
#(
   parameter int REG_W  = 5,
   parameter int WSEL_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_en,
   input  logic              i_clr,
   input  logic              i_wen,
   input  logic [REG_W-1:0]  i_wreg,
   input  logic [WSEL_W-1:0] i_wsel,
   output logic              o_wen,
   output logic [REG_W-1:0]  o_wreg,
   output logic [WSEL_W-1:0] o_wsel
);

   logic              r_wen;
   logic [REG_W-1:0]  r_wreg;
   logic [WSEL_W-1:0] r_wsel;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wen  <= 1'b0;
         r_wreg <= '0;
         r_wsel <= '0;
      end else if (i_en) begin
         if (i_clr) begin
            r_wen  <= 1'b0;
            r_wreg <= '0;
            r_wsel <= '0;
         end else begin
            r_wen  <= i_wen;
            r_wreg <= i_wreg;
            r_wsel <= i_wsel;
         end
      end
   end

   assign o_wen  = r_wen;
   assign o_wreg = r_wreg;
   assign o_wsel = r_wsel;

endmodule

// File: rtl/hazard_detect.sv
// ID-stage hazard detection: tracks EX/MEM destinations and raises forwarding flags
// and load-use style stall/bubble controls combinationally in the same cycle.
module hazard_detect
   import hazard_detect_pkg::*;
#(
   parameter int REG_W  = 5,
   parameter int WSEL_W = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              hold,
   input  logic              id_valid,
   input  logic [REG_W-1:0]  id_rs,
   input  logic [REG_W-1:0]  id_rt,
   input  logic              id_use_rs,
   input  logic              id_use_rt,
   input  logic              id_wen,
   input  logic [REG_W-1:0]  id_wreg,
   input  logic [WSEL_W-1:0] id_rf_wsel,
   output logic              id_ex_hazard_mem,
   output logic              id_ex_rs_hazard_reg,
   output logic              id_ex_rt_hazard_reg,
   output logic              id_mem_rs_hazard_mem,
   output logic              id_mem_rt_hazard_mem,
   output logic              id_mem_rs_hazard_reg,
   output logic              id_mem_rt_hazard_reg,
   output logic              stall_pc,
   output logic              stall_ifid,
   output logic              bubble_idex,
   output logic [WSEL_W-1:0] ex_wsel_q,
   output logic [WSEL_W-1:0] mem_wsel_q
);

   logic              w_ex_wen,  w_mem_wen;
   logic [REG_W-1:0]  w_ex_wreg, w_mem_wreg;
   logic [WSEL_W-1:0] w_ex_wsel, w_mem_wsel;
   logic              w_adv, w_ex_clr, w_active, w_stall;
   logic              w_ex_rs_m, w_ex_rt_m, w_mem_rs_m, w_mem_rt_m;
   logic              w_ex_alu, w_ex_nf, w_mem_ram;

   assign w_adv    = ~hold;
   assign w_ex_clr = w_stall | ~id_valid;

   hazard_dst_reg #(.REG_W(REG_W), .WSEL_W(WSEL_W)) u_ex (
      .clk    (clk),
      .reset  (reset),
      .i_en   (w_adv),
      .i_clr  (w_ex_clr),
      .i_wen  (id_wen),
      .i_wreg (id_wreg),
      .i_wsel (id_rf_wsel),
      .o_wen  (w_ex_wen),
      .o_wreg (w_ex_wreg),
      .o_wsel (w_ex_wsel)
   );

   hazard_dst_reg #(.REG_W(REG_W), .WSEL_W(WSEL_W)) u_mem (
      .clk    (clk),
      .reset  (reset),
      .i_en   (w_adv),
      .i_clr  (1'b0),
      .i_wen  (w_ex_wen),
      .i_wreg (w_ex_wreg),
      .i_wsel (w_ex_wsel),
      .o_wen  (w_mem_wen),
      .o_wreg (w_mem_wreg),
      .o_wsel (w_mem_wsel)
   );

   // Gating on reset makes a mid-stall reset drop every output without waiting for a clock.
   assign w_active = id_valid & ~reset;

   assign w_ex_rs_m  = w_active & id_use_rs & w_ex_wen  & (w_ex_wreg  != '0) & (w_ex_wreg  == id_rs);
   assign w_ex_rt_m  = w_active & id_use_rt & w_ex_wen  & (w_ex_wreg  != '0) & (w_ex_wreg  == id_rt);
   assign w_mem_rs_m = w_active & id_use_rs & w_mem_wen & (w_mem_wreg != '0) & (w_mem_wreg == id_rs);
   assign w_mem_rt_m = w_active & id_use_rt & w_mem_wen & (w_mem_wreg != '0) & (w_mem_wreg == id_rt);

   assign w_ex_alu  = (w_ex_wsel == WSEL_W'(WB_ALU));
   assign w_ex_nf   = is_ex_nonfwd(3'(w_ex_wsel));
   assign w_mem_ram = (w_mem_wsel == WSEL_W'(WB_RAM));

   assign id_ex_hazard_mem     = (w_ex_rs_m | w_ex_rt_m) & w_ex_nf;
   assign id_ex_rs_hazard_reg  = w_ex_rs_m & w_ex_alu;
   assign id_ex_rt_hazard_reg  = w_ex_rt_m & w_ex_alu;

   // Any EX match shadows MEM for that source, even when EX itself raises no flag.
   assign id_mem_rs_hazard_mem = w_mem_rs_m & ~w_ex_rs_m &  w_mem_ram;
   assign id_mem_rt_hazard_mem = w_mem_rt_m & ~w_ex_rt_m &  w_mem_ram;
   assign id_mem_rs_hazard_reg = w_mem_rs_m & ~w_ex_rs_m & ~w_mem_ram;
   assign id_mem_rt_hazard_reg = w_mem_rt_m & ~w_ex_rt_m & ~w_mem_ram;

   assign w_stall     = id_ex_hazard_mem & ~hold;
   assign stall_pc    = w_stall;
   assign stall_ifid  = w_stall;
   assign bubble_idex = w_stall;

   assign ex_wsel_q  = w_ex_wsel;
   assign mem_wsel_q = w_mem_wsel;

endmodule

// File: tb/tb_hazard_detect.sv
// Directed table of per-cycle ID instructions with hand-computed flags, plus a
// hand-written asynchronous reset-during-stall sequence.
module tb_hazard_detect;

   localparam logic [2:0] ALU = 3'b001;
   localparam logic [2:0] RAM = 3'b011;
   localparam logic [2:0] PC8 = 3'b110;

   // flag bit order: ex_mem, ex_rs_reg, ex_rt_reg, mem_rs_mem, mem_rt_mem, mem_rs_reg, mem_rt_reg
   localparam logic [6:0] F_EXM = 7'h40, F_EXRS = 7'h20, F_EXRT = 7'h10;
   localparam logic [6:0] F_MRSM = 7'h08, F_MRTM = 7'h04, F_MRSR = 7'h02, F_MRTR = 7'h01;

   logic       clk = 1'b0;
   logic       reset, hold, id_valid, id_use_rs, id_use_rt, id_wen;
   logic [4:0] id_rs, id_rt, id_wreg;
   logic [2:0] id_rf_wsel;
   logic       id_ex_hazard_mem, id_ex_rs_hazard_reg, id_ex_rt_hazard_reg;
   logic       id_mem_rs_hazard_mem, id_mem_rt_hazard_mem;
   logic       id_mem_rs_hazard_reg, id_mem_rt_hazard_reg;
   logic       stall_pc, stall_ifid, bubble_idex;
   logic [2:0] ex_wsel_q, mem_wsel_q;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   hazard_detect #(.REG_W(5), .WSEL_W(3)) dut (
      .clk                  (clk),
      .reset                (reset),
      .hold                 (hold),
      .id_valid             (id_valid),
      .id_rs                (id_rs),
      .id_rt                (id_rt),
      .id_use_rs            (id_use_rs),
      .id_use_rt            (id_use_rt),
      .id_wen               (id_wen),
      .id_wreg              (id_wreg),
      .id_rf_wsel           (id_rf_wsel),
      .id_ex_hazard_mem     (id_ex_hazard_mem),
      .id_ex_rs_hazard_reg  (id_ex_rs_hazard_reg),
      .id_ex_rt_hazard_reg  (id_ex_rt_hazard_reg),
      .id_mem_rs_hazard_mem (id_mem_rs_hazard_mem),
      .id_mem_rt_hazard_mem (id_mem_rt_hazard_mem),
      .id_mem_rs_hazard_reg (id_mem_rs_hazard_reg),
      .id_mem_rt_hazard_reg (id_mem_rt_hazard_reg),
      .stall_pc             (stall_pc),
      .stall_ifid           (stall_ifid),
      .bubble_idex          (bubble_idex),
      .ex_wsel_q            (ex_wsel_q),
      .mem_wsel_q           (mem_wsel_q)
   );

   typedef struct {
      logic       hold, valid;
      logic [4:0] rs, rt;
      logic       urs, urt, wen;
      logic [4:0] wreg;
      logic [2:0] wsel;
      logic [6:0] flags;
      logic       stall;
      logic [2:0] exq, memq;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic h, input logic v, input logic [4:0] rs, input logic [4:0] rt,
                               input logic urs, input logic urt, input logic wen, input logic [4:0] wreg,
                               input logic [2:0] wsel, input logic [6:0] fl, input logic st,
                               input logic [2:0] exq, input logic [2:0] memq);
      vec_t r;
      r.hold = h; r.valid = v; r.rs = rs; r.rt = rt; r.urs = urs; r.urt = urt;
      r.wen = wen; r.wreg = wreg; r.wsel = wsel; r.flags = fl; r.stall = st;
      r.exq = exq; r.memq = memq;
      return r;
   endfunction

   task automatic drive(input vec_t v);
      hold = v.hold; id_valid = v.valid; id_rs = v.rs; id_rt = v.rt;
      id_use_rs = v.urs; id_use_rt = v.urt; id_wen = v.wen;
      id_wreg = v.wreg; id_rf_wsel = v.wsel;
   endtask

   task automatic cmp(input string nm, input logic [9:0] act, input logic [9:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b want %b", nm, act, exp);
      end
   endtask

   task automatic check(input string nm, input logic [6:0] fl, input logic st,
                        input logic [2:0] exq, input logic [2:0] memq);
      cmp({nm, " flags/stall"},
          {id_ex_hazard_mem, id_ex_rs_hazard_reg, id_ex_rt_hazard_reg,
           id_mem_rs_hazard_mem, id_mem_rt_hazard_mem, id_mem_rs_hazard_reg,
           id_mem_rt_hazard_reg, stall_pc, stall_ifid, bubble_idex},
          {fl, {3{st}}});
      cmp({nm, " ex_wsel_q"},  {7'd0, ex_wsel_q},  {7'd0, exq});
      cmp({nm, " mem_wsel_q"}, {7'd0, mem_wsel_q}, {7'd0, memq});
   endtask

   initial begin
      //             h v  rs  rt urs urt wen wreg wsel  flags           st exq memq
      vecs.push_back(mk(0,1,  1,  2, 1, 1, 1,  3, ALU, 7'h0,          0, 0, 0)); // addu $3
      vecs.push_back(mk(0,1,  3,  4, 1, 1, 0,  0, 0,   F_EXRS,        0, 1, 0)); // beq $3,$4
      vecs.push_back(mk(0,1,  9, 10, 1, 1, 1,  8, ALU, 7'h0,          0, 0, 1)); // unrelated
      vecs.push_back(mk(0,1, 29,  0, 1, 0, 1,  5, RAM, 7'h0,          0, 1, 0)); // lw $5
      vecs.push_back(mk(0,1,  5,  0, 1, 1, 0,  0, 0,   F_EXM,         1, 3, 1)); // bne $5,$0
      vecs.push_back(mk(0,1,  5,  0, 1, 1, 0,  0, 0,   F_MRSM,        0, 0, 3));
      vecs.push_back(mk(0,1,  0,  0, 0, 0, 1, 31, PC8, 7'h0,          0, 0, 0)); // jal
      vecs.push_back(mk(0,1, 31,  0, 1, 0, 0,  0, 0,   F_EXM,         1, 6, 0)); // jr $31
      vecs.push_back(mk(0,1, 31,  0, 1, 0, 0,  0, 0,   F_MRSR,        0, 0, 6));
      vecs.push_back(mk(0,1,  0,  0, 0, 0, 1, 31, PC8, 7'h0,          0, 0, 0)); // jal
      vecs.push_back(mk(0,0, 31,  0, 1, 0, 0,  0, 0,   7'h0,          0, 6, 0)); // invalid
      vecs.push_back(mk(0,0, 31,  0, 1, 0, 0,  0, 0,   7'h0,          0, 0, 6)); // invalid
      vecs.push_back(mk(0,1, 31,  0, 1, 0, 0,  0, 0,   7'h0,          0, 0, 0)); // jr 3 behind
      vecs.push_back(mk(0,1,  1,  2, 1, 1, 1,  7, ALU, 7'h0,          0, 0, 0)); // addu $7
      vecs.push_back(mk(0,1,  1,  2, 1, 1, 1,  7, ALU, 7'h0,          0, 1, 0)); // or $7
      vecs.push_back(mk(0,1,  7,  7, 1, 1, 1,  0, ALU, F_EXRS|F_EXRT, 0, 1, 1)); // rd $7,$7 wr $0
      vecs.push_back(mk(0,1,  0,  0, 1, 1, 0,  0, 0,   7'h0,          0, 1, 1)); // rd $0
      vecs.push_back(mk(0,1, 29,  0, 1, 0, 1,  9, RAM, 7'h0,          0, 0, 1)); // lw $9
      vecs.push_back(mk(1,1,  0,  9, 1, 1, 0,  0, 0,   F_EXM,         0, 3, 0)); // held
      vecs.push_back(mk(1,1,  0,  9, 1, 1, 0,  0, 0,   F_EXM,         0, 3, 0));
      vecs.push_back(mk(1,1,  0,  9, 1, 1, 0,  0, 0,   F_EXM,         0, 3, 0));
      vecs.push_back(mk(0,1,  0,  9, 1, 1, 0,  0, 0,   F_EXM,         1, 3, 0)); // released
      vecs.push_back(mk(0,1,  0,  9, 1, 1, 0,  0, 0,   F_MRTM,        0, 0, 3));
      vecs.push_back(mk(0,1,  1,  2, 1, 1, 1, 12, ALU, 7'h0,          0, 0, 0)); // addu $12
      vecs.push_back(mk(0,0,  0,  0, 0, 0, 0,  0, 0,   7'h0,          0, 1, 0)); // invalid
      vecs.push_back(mk(0,1,  0, 12, 1, 1, 0,  0, 0,   F_MRTR,        0, 0, 1)); // rd $12

      reset = 1'b1;
      drive(mk(0,1, 5, 5, 1, 1, 1, 5, RAM, 7'h0, 0, 0, 0));
      #3;
      check("in_reset", 7'h0, 1'b0, 3'd0, 3'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         drive(vecs[i]);
         @(negedge clk);
         check($sformatf("vec%0d", i), vecs[i].flags, vecs[i].stall, vecs[i].exq, vecs[i].memq);
         @(posedge clk);
         #1;
      end

      // Reset dropped onto a live stall: EX holds lw $5, MEM holds addu $6.
      drive(mk(0,1, 1, 2, 1, 1, 1, 6, ALU, 7'h0, 0, 0, 0));
      @(posedge clk); #1;
      drive(mk(0,1, 29, 0, 1, 0, 1, 5, RAM, 7'h0, 0, 0, 0));
      @(posedge clk); #1;
      drive(mk(0,1, 5, 6, 1, 1, 0, 0, 0, 7'h0, 0, 0, 0));
      @(negedge clk);
      check("pre_reset", F_EXM | F_MRTR, 1'b1, 3'd3, 3'd1);
      #1 reset = 1'b1;
      #1;
      check("async_reset", 7'h0, 1'b0, 3'd0, 3'd0);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("post_reset", 7'h0, 1'b0, 3'd0, 3'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
